floppy_voice_alloc: RTL and testbench
=====================================

Name: floppy_voice_alloc

Overview:
Voice allocator and sequencer for the floppy note registers. It accepts decoded MIDI note-on/note-off events and assigns each to one of NUM_VOICES floppy channels. It then issues single-cycle writes on the register bus that drives the per-floppy note/enable registers (bit 7 = enable, bits 6:0 = note). It sits between the MIDI decoder and the register controller, and is the only writer of the floppy note registers.

Parameters:
NUM_VOICES, 6, number of floppy channels managed; legal range 1..8.
BASE_ADDR, 6'h00, register address of voice 0; voice i uses BASE_ADDR+i.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
msg_valid  input  1  event present on msg_* this cycle
msg_ready  output  1  allocator can accept an event this cycle
msg_on  input  1  1 = note-on, 0 = note-off
msg_note  input  7  MIDI note number
msg_vel  input  7  velocity; note-on with velocity 0 is treated as note-off
all_off  input  1  single-cycle pulse requesting that all voices be silenced
reg_addr  output  6  register address
write  output  1  always 1 when new_req=1
new_req  output  1  one-cycle register request strobe
write_value  output  8  {enable, note[6:0]}
voice_active  output  NUM_VOICES  per-voice active flags
busy  output  1  FSM not in IDLE, or all_off pending

Behaviour:
- Reset values: msg_ready=0 during reset, then 1 in IDLE. new_req=0, write=0, reg_addr=0, write_value=0, voice_active=0, busy=0. Internal state also resets: voice note table=0, steal_ptr=0, pending all_off cleared.
- Reset mid-operation aborts any in-flight event or flush; no further writes are issued.
- Register bus has no backpressure: each new_req pulse is one complete write. reg_addr, write and write_value are valid only while new_req=1; otherwise they hold their last value.
- FSM states: IDLE, LOOKUP, WRITE, FLUSH.
- IDLE:
  - msg_ready=1 unless all_off is pending or asserted this cycle.
  - all_off (pending or current) has priority: go to FLUSH with idx=0, msg_ready=0.
  - Else, if msg_valid: latch the event and go to LOOKUP.
- LOOKUP (one cycle): compute the target voice.
  - Effective note-on (msg_on=1 and msg_vel!=0):
    - If an active voice already holds msg_note, target it (retrigger).
    - Else target the lowest-index inactive voice.
    - Else (all voices busy), steal voice steal_ptr, then steal_ptr = (steal_ptr+1) mod NUM_VOICES.
  - Note-off: target the lowest-index active voice holding msg_note.
    - If there is none, drop the event: no write, return to IDLE.
- WRITE (one cycle): new_req=1, write=1, reg_addr=BASE_ADDR+target.
  - Note-on: write_value={1,note}; table[target]=note; active[target]=1.
  - Note-off: write_value={0,stored note}; active[target]=0.
  - Return to IDLE.
- Latency: event accepted at cycle N → new_req at N+2. Accepted while idle → msg_ready high again at N+3. Maximum throughput is one event per 3 cycles.
- FLUSH:
  - Issues NUM_VOICES writes on consecutive cycles, addresses BASE_ADDR..BASE_ADDR+NUM_VOICES-1, write_value=8'h00 each.
  - All active flags are cleared as their writes issue; steal_ptr resets to 0.
  - Returns to IDLE after the last write.
- all_off asserted outside IDLE sets a pending flag. The current event's write completes first; FLUSH begins on the first IDLE cycle. Multiple pulses before service collapse into one flush. all_off arriving during FLUSH is absorbed.
- voice_active reflects the table state registered after each write.

Test Plan:
- Reset, then note-on 60 vel 100 accepted at cycle N → at N+2: new_req=1, reg_addr=0, write_value=8'hBC; voice_active=6'b000001.
- Note-ons 60,62,64,65,67,69 → writes to addr 0..5 with 8'hBC,BE,C0,C1,C3,C5. Then note-on 71 → addr 0 gets 8'hC7 (steal, steal_ptr→1). Then note-on 72 → addr 1 gets 8'hC8.
- Note-on 60 then note-off 60 → second write addr 0 value 8'h3C, voice_active=0. Note-off 61 (never on) → no new_req at all; msg_ready returns high 2 cycles after accept.
- Note-on 60 vel 0 after note-on 60 → treated as note-off: addr 0 value 8'h3C. Repeat note-on 60 while active → retrigger on addr 0, no second voice used.
- all_off during the LOOKUP of note-on 62 → write addr 0 value 8'hBE first, then 6 consecutive writes addr 0..5 value 8'h00. msg_ready=0 throughout; voice_active=0 after.
- rst asserted in WRITE-preceding LOOKUP → no new_req; all outputs at reset values the next cycle. The next note-on goes to voice 0.

Source files
------------

// File: rtl/floppy_voice_alloc.sv
// Voice allocator and sequencer for the floppy note registers.
// Takes decoded MIDI note-on/off events, maps each onto one of NUM_VOICES floppy channels
// (retrigger, then free voice, then round-robin steal), and issues single-cycle register
// writes of {enable, note[6:0]} to BASE_ADDR + voice. An all_off pulse flushes every voice.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   msg_valid_i/ready_o   event handshake; msg_on_i, msg_note_i, msg_vel_i carry the event
//   all_off_i             pulse: silence all voices
//   reg_addr_o, write_o, new_req_o, write_value_o   register bus (valid while new_req_o=1)
//   voice_active_o        per-voice active flags
//   busy_o                not idle, or a flush is pending
module floppy_voice_alloc #(
  parameter int unsigned NUM_VOICES = 6,
  parameter logic [5:0]  BASE_ADDR  = 6'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  input  logic                  msg_on_i,
  input  logic [6:0]            msg_note_i,
  input  logic [6:0]            msg_vel_i,
  input  logic                  all_off_i,
  output logic [5:0]            reg_addr_o,
  output logic                  write_o,
  output logic                  new_req_o,
  output logic [7:0]            write_value_o,
  output logic [NUM_VOICES-1:0] voice_active_o,
  output logic                  busy_o
);

  localparam logic [2:0] LastVoice = 3'(NUM_VOICES - 1);
  localparam logic [3:0] FlushEnd  = 4'(NUM_VOICES);

  typedef enum logic [1:0] {StIdle, StLookup, StWrite, StFlush} state_e;

  state_e                state_q, state_d;
  logic                  ev_on_q, ev_on_d;
  logic [6:0]            ev_note_q, ev_note_d;
  logic                  pend_q, pend_d;
  logic [3:0]            idx_q, idx_d;
  logic [2:0]            steal_q, steal_d;
  logic [6:0]            notes_q [NUM_VOICES];
  logic [6:0]            notes_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [5:0]            addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  new_req_q, new_req_d;
  logic [7:0]            wval_q, wval_d;

  logic                  hit, free, do_write;
  logic [2:0]            hit_idx, free_idx, tgt;

  // Lowest-index active voice holding the latched note, and lowest-index idle voice.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 3'd0;
    free     = 1'b0;
    free_idx = 3'd0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (!hit && active_q[i] && notes_q[i] == ev_note_q) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      if (!free && !active_q[i]) begin
        free     = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    steal_d   = steal_q;
    notes_d   = notes_q;
    active_d  = active_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wval_d    = wval_q;
    new_req_d = 1'b0;
    do_write  = 1'b0;
    tgt       = 3'd0;

    // Remember all_off while an event is in flight; a flush in progress absorbs it.
    if (all_off_i && (state_q == StLookup || state_q == StWrite)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q || all_off_i) begin
          // Issue the voice-0 write on entry so flush writes land on consecutive cycles.
          pend_d      = 1'b0;
          steal_d     = 3'd0;
          addr_d      = BASE_ADDR;
          write_d     = 1'b1;
          wval_d      = 8'h00;
          new_req_d   = 1'b1;
          active_d[0] = 1'b0;
          idx_d       = 4'd1;
          state_d     = StFlush;
        end else if (msg_valid_i) begin
          ev_on_d   = msg_on_i && (msg_vel_i != 7'd0);
          ev_note_d = msg_note_i;
          state_d   = StLookup;
        end
      end
      StLookup: begin
        state_d = StIdle;
        if (ev_on_q) begin
          do_write = 1'b1;
          if (hit) begin
            tgt = hit_idx;
          end else if (free) begin
            tgt = free_idx;
          end else begin
            tgt     = steal_q;
            steal_d = (steal_q == LastVoice) ? 3'd0 : steal_q + 3'd1;
          end
        end else if (hit) begin
          do_write = 1'b1;
          tgt      = hit_idx;
        end
        // Bus outputs and table are registered here, so both appear in the WRITE cycle.
        if (do_write) begin
          addr_d    = BASE_ADDR + 6'(tgt);
          write_d   = 1'b1;
          new_req_d = 1'b1;
          state_d   = StWrite;
          if (ev_on_q) begin
            wval_d        = {1'b1, ev_note_q};
            notes_d[tgt]  = ev_note_q;
            active_d[tgt] = 1'b1;
          end else begin
            wval_d        = {1'b0, notes_q[tgt]};
            active_d[tgt] = 1'b0;
          end
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StFlush: begin
        if (idx_q == FlushEnd) begin
          state_d = StIdle;
        end else begin
          addr_d               = BASE_ADDR + 6'(idx_q);
          write_d              = 1'b1;
          wval_d               = 8'h00;
          new_req_d            = 1'b1;
          active_d[idx_q[2:0]] = 1'b0;
          idx_d                = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ev_on_q   <= 1'b0;
      ev_note_q <= 7'd0;
      pend_q    <= 1'b0;
      idx_q     <= 4'd0;
      steal_q   <= 3'd0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        notes_q[i] <= 7'd0;
      end
      active_q  <= '0;
      addr_q    <= 6'd0;
      write_q   <= 1'b0;
      new_req_q <= 1'b0;
      wval_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      steal_q   <= steal_d;
      notes_q   <= notes_d;
      active_q  <= active_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      new_req_q <= new_req_d;
      wval_q    <= wval_d;
    end
  end

  assign msg_ready_o    = !rst_i && (state_q == StIdle) && !pend_q && !all_off_i;
  assign busy_o         = (state_q != StIdle) || pend_q;
  assign reg_addr_o     = addr_q;
  assign write_o        = write_q;
  assign new_req_o      = new_req_q;
  assign write_value_o  = wval_q;
  assign voice_active_o = active_q;

endmodule

// File: tb/tb_floppy_voice_alloc.sv
module tb_floppy_voice_alloc;
  localparam int NV = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          msg_valid = 1'b0;
  logic          msg_ready;
  logic          msg_on = 1'b0;
  logic [6:0]    msg_note = 7'd0;
  logic [6:0]    msg_vel = 7'd0;
  logic          all_off = 1'b0;
  logic [5:0]    reg_addr;
  logic          write_s;
  logic          new_req;
  logic [7:0]    write_value;
  logic [NV-1:0] voice_active;
  logic          busy;

  floppy_voice_alloc #(.NUM_VOICES(NV), .BASE_ADDR(6'h00)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .msg_valid_i    (msg_valid),
    .msg_ready_o    (msg_ready),
    .msg_on_i       (msg_on),
    .msg_note_i     (msg_note),
    .msg_vel_i      (msg_vel),
    .all_off_i      (all_off),
    .reg_addr_o     (reg_addr),
    .write_o        (write_s),
    .new_req_o      (new_req),
    .write_value_o  (write_value),
    .voice_active_o (voice_active),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc = -1: any cycle, -2: exactly one cycle after the previous write.
  typedef struct {
    logic [5:0] a;
    logic [7:0] v;
    int         c;
  } exp_t;
  exp_t sb[$];

  logic [6:0]    m_note [NV];
  logic [NV-1:0] m_act;
  int            m_steal;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_note[i] = 7'd0;
    m_act   = '0;
    m_steal = 0;
  endtask

  task automatic model_event(input bit on, input logic [6:0] note, input logic [6:0] vel,
                             output bit wr, output logic [5:0] a, output logic [7:0] v);
    int hit = -1, fr = -1, t = 0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m_act[i] && m_note[i] == note) hit = i;
      if (!m_act[i]) fr = i;
    end
    wr = 1'b0;
    v  = 8'h00;
    if (on && vel != 0) begin
      if (hit >= 0) t = hit;
      else if (fr >= 0) t = fr;
      else begin
        t       = m_steal;
        m_steal = (m_steal + 1) % NV;
      end
      wr        = 1'b1;
      v         = {1'b1, note};
      m_note[t] = note;
      m_act[t]  = 1'b1;
    end else if (hit >= 0) begin
      t        = hit;
      wr       = 1'b1;
      v        = {1'b0, m_note[t]};
      m_act[t] = 1'b0;
    end
    a = 6'(t);
  endtask

  task automatic model_flush();
    for (int i = 0; i < NV; i++) sb.push_back('{6'(i), 8'h00, (i == 0) ? -1 : -2});
    m_act   = '0;
    m_steal = 0;
  endtask

  // Scoreboard monitor: every request must match the oldest expected write.
  always @(negedge clk) begin
    if (new_req === 1'b1) begin
      exp_t e;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("wr_addr", 32'(reg_addr), 32'(e.a));
        check_eq("wr_value", 32'(write_value), 32'(e.v));
        check_eq("wr_write", 32'(write_s), 1);
        if (e.c >= 0) check_eq("wr_latency", cyc, e.c);
        else if (e.c == -2) check_eq("wr_consecutive", cyc, last_wr + 1);
      end
      last_wr = cyc;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (msg_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 40), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    msg_valid = 1'b0;
    all_off = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(msg_ready), 0);
    check_eq("rst_new_req", 32'(new_req), 0);
    check_eq("rst_write", 32'(write_s), 0);
    check_eq("rst_addr", 32'(reg_addr), 0);
    check_eq("rst_value", 32'(write_value), 0);
    check_eq("rst_active", 32'(voice_active), 0);
    check_eq("rst_busy", 32'(busy), 0);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(msg_ready), 1);
  endtask

  task automatic send(input bit on, input logic [6:0] note, input logic [6:0] vel);
    bit wr;
    logic [5:0] a;
    logic [7:0] v;
    int acc;
    wait_ready("send_ready_timeout");
    msg_valid = 1'b1;
    msg_on    = on;
    msg_note  = note;
    msg_vel   = vel;
    acc       = cyc;
    model_event(on, note, vel, wr, a, v);
    if (wr) sb.push_back('{a, v, acc + 2});
    @(negedge clk);
    msg_valid = 1'b0;
    @(negedge clk);
    if (!wr) begin
      check_eq("drop_no_req", 32'(new_req), 0);
      check_eq("drop_ready_n2", 32'(msg_ready), 1);
    end else begin
      check_eq("ready_low_n2", 32'(msg_ready), 0);
      @(negedge clk);
      check_eq("ready_back_n3", 32'(msg_ready), 1);
    end
    check_eq("voice_active", 32'(voice_active), 32'(m_act));
  endtask

  task automatic pulse_all_off();
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr;
    logic [5:0] a;
    logic [7:0] v;
    logic [6:0] fill [NV];
    int acc;
    fill[0] = 7'd60; fill[1] = 7'd62; fill[2] = 7'd64;
    fill[3] = 7'd65; fill[4] = 7'd67; fill[5] = 7'd69;

    // Fill all voices, then two steals; refill after a flush and steal from voice 0 again.
    do_reset();
    for (int i = 0; i < NV; i++) send(1'b1, fill[i], 7'd100);
    send(1'b1, 7'd71, 7'd100);
    send(1'b1, 7'd72, 7'd90);
    check_eq("busy_idle", 32'(busy), 0);
    model_flush();
    pulse_all_off();
    @(negedge clk);
    pulse_all_off();  // lands mid-flush and must be absorbed
    wait_ready("flush_done_timeout");
    check_eq("flush_active", 32'(voice_active), 0);
    for (int i = 0; i < NV; i++) send(1'b1, fill[i], 7'd80);
    send(1'b1, 7'd74, 7'd80);

    // Note-off, unknown note-off, retrigger, velocity-0 note-off.
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b0, 7'd60, 7'd0);
    send(1'b0, 7'd61, 7'd64);
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd60, 7'd50);
    send(1'b1, 7'd60, 7'd0);

    // all_off during LOOKUP (twice, collapsing into one flush).
    do_reset();
    wait_ready("ao_ready_timeout");
    msg_valid = 1'b1; msg_on = 1'b1; msg_note = 7'd62; msg_vel = 7'd100;
    acc = cyc;
    model_event(1'b1, 7'd62, 7'd100, wr, a, v);
    sb.push_back('{a, v, acc + 2});
    model_flush();
    @(negedge clk);
    msg_valid = 1'b0;
    pulse_all_off();
    pulse_all_off();
    for (int k = acc + 3; k <= acc + 3 + NV; k++) begin
      check_eq("ao_ready_low", 32'(msg_ready), 0);
      check_eq("ao_busy", 32'(busy), 1);
      @(negedge clk);
    end
    check_eq("ao_ready_back", 32'(msg_ready), 1);
    check_eq("ao_active", 32'(voice_active), 0);

    // Reset during LOOKUP: the write is aborted and the next note lands on voice 0.
    send(1'b1, 7'd50, 7'd100);
    send(1'b1, 7'd52, 7'd100);
    wait_ready("rl_ready_timeout");
    msg_valid = 1'b1; msg_on = 1'b1; msg_note = 7'd55; msg_vel = 7'd100;
    @(negedge clk);
    msg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rl_new_req", 32'(new_req), 0);
    check_eq("rl_addr", 32'(reg_addr), 0);
    check_eq("rl_value", 32'(write_value), 0);
    check_eq("rl_active", 32'(voice_active), 0);
    check_eq("rl_busy", 32'(busy), 0);
    check_eq("rl_ready", 32'(msg_ready), 0);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    send(1'b1, 7'd64, 7'd100);

    repeat (10) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
